// File: rtl/con_eval_unit.sv
// con_eval_unit: conditional-branch evaluator beside the datapath bus.
// Compares operand A against zero or against a second operand B using the
// instruction's condition field, registers and holds the branch-taken
// result, and keeps a saturating count of taken evaluations.
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for the A strobe; latches A, cond and mode on CONin
//   S_WAIT_B | two-operand mode, A held; latches B on the next CONin
//   S_EVAL   | operands stable; comparison captured into the result stage
//
// The result stage (res_q/fire_q) sits between S_EVAL and the outputs, so
// CONout/CONvalid appear two edges after the final operand strobe.
module con_eval_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int COND_BITS  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  CONin,
    input  logic                  CONclr,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic [COND_BITS-1:0]  IrBits,
    input  logic                  CmpMode,
    output logic                  CONout,
    output logic                  CONvalid,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  TakenCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_B = 2'd1,
        S_EVAL   = 2'd2
    } state_t;

    localparam logic [2:0] C_EQ     = 3'b000;
    localparam logic [2:0] C_NE     = 3'b001;
    localparam logic [2:0] C_GE     = 3'b010;
    localparam logic [2:0] C_LT     = 3'b011;
    localparam logic [2:0] C_GT     = 3'b100;
    localparam logic [2:0] C_LE     = 3'b101;
    localparam logic [2:0] C_ALWAYS = 3'b110;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [COND_BITS-1:0]  cond_q;
    logic                  mode_q;

    logic                  ld_a, ld_b, eval_go;

    logic [DATA_WIDTH:0]   ext_a, ext_b, diff;
    logic                  is_lt, is_eq, cond_res;

    logic                  res_q, fire_q;
    logic                  con_q, valid_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and operand-load decode; CONclr overrides any strobe
    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        eval_go = 1'b0;
        if (CONclr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (CONin) begin
                        ld_a    = 1'b1;
                        state_d = CmpMode ? S_WAIT_B : S_EVAL;
                    end
                end
                S_WAIT_B: begin
                    if (CONin) begin
                        ld_b    = 1'b1;
                        state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    eval_go = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Operand, condition and mode latches; untouched by CONclr
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_q    <= '0;
            b_q    <= '0;
            cond_q <= '0;
            mode_q <= 1'b0;
        end else begin
            if (ld_a) begin
                a_q    <= BusMuxOut;
                cond_q <= IrBits;
                mode_q <= CmpMode;
            end
            if (ld_b) begin
                b_q <= BusMuxOut;
            end
        end
    end

    // One extra bit of width makes A-B exact for every signed operand pair
    always_comb begin
        ext_a = {a_q[DATA_WIDTH-1], a_q};
        ext_b = mode_q ? {b_q[DATA_WIDTH-1], b_q} : '0;
        diff  = ext_a - ext_b;
        is_lt = diff[DATA_WIDTH];
        is_eq = (diff == '0);
        case (cond_q)
            C_EQ:     cond_res = is_eq;
            C_NE:     cond_res = !is_eq;
            C_GE:     cond_res = !is_lt;
            C_LT:     cond_res = is_lt;
            C_GT:     cond_res = !is_lt && !is_eq;
            C_LE:     cond_res = is_lt || is_eq;
            C_ALWAYS: cond_res = 1'b1;
            default:  cond_res = 1'b0;
        endcase
    end

    // Result stage: captures the comparison on the S_EVAL exit edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            res_q  <= 1'b0;
            fire_q <= 1'b0;
        end else if (CONclr) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= eval_go;
            if (eval_go) begin
                res_q <= cond_res;
            end
        end
    end

    // Published result and single-cycle valid pulse; CONclr drops a pending result
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            con_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (CONclr) begin
            con_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= fire_q;
            if (fire_q) begin
                con_q <= res_q;
            end
        end
    end

    // Saturating taken counter, advanced together with the valid pulse
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (!CONclr && fire_q && res_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign CONout     = con_q;
    assign CONvalid   = valid_q;
    assign TakenCount = cnt_q;

endmodule

// File: tb/tb_con_eval_unit.sv
// Bench for con_eval_unit: directed scenarios plus randomized evaluations,
// checked against a signed-integer reference of the branch conditions.
module tb_con_eval_unit;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          clk;
    logic          clr;
    logic          CONin;
    logic          CONclr;
    logic [DW-1:0] BusMuxOut;
    logic [2:0]    IrBits;
    logic          CmpMode;
    logic          CONout;
    logic          CONvalid;
    logic          Busy;
    logic [CW-1:0] TakenCount;

    int vectors    = 0;
    int miscompares = 0;
    int exp_cnt    = 0;
    bit exp_out    = 1'b0;

    con_eval_unit #(.DATA_WIDTH(DW), .COND_BITS(3), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .clr        (clr),
        .CONin      (CONin),
        .CONclr     (CONclr),
        .BusMuxOut  (BusMuxOut),
        .IrBits     (IrBits),
        .CmpMode    (CmpMode),
        .CONout     (CONout),
        .CONvalid   (CONvalid),
        .Busy       (Busy),
        .TakenCount (TakenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_cond(input logic [2:0] c, input logic [31:0] a,
                                    input logic [31:0] b, input bit mode);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = mode ? longint'($signed(b)) : 64'sd0;
        case (c)
            3'd0:    return sa == sb;
            3'd1:    return sa != sb;
            3'd2:    return sa >= sb;
            3'd3:    return sa <  sb;
            3'd4:    return sa >  sb;
            3'd5:    return sa <= sb;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_result(input bit r);
        exp_out = r;
        if (r && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    // Entered at a negedge with the unit idle; leaves at a negedge, idle again.
    task automatic run_eval(input bit mode, input logic [2:0] cond,
                            input logic [31:0] a, input logic [31:0] b, input string tag);
        bit r;
        r = ref_cond(cond, a, b, mode);
        CONin = 1'b1; BusMuxOut = a; IrBits = cond; CmpMode = mode;
        @(negedge clk);
        check({tag, ".busy_a"}, 32'(Busy), 32'd1);
        if (mode) begin
            BusMuxOut = b; IrBits = ~cond; CmpMode = 1'b0;
            @(negedge clk);
            check({tag, ".busy_b"}, 32'(Busy), 32'd1);
        end
        CONin = 1'b0; BusMuxOut = $urandom; IrBits = 3'($urandom); CmpMode = 1'($urandom);
        @(negedge clk);
        check({tag, ".early_valid"}, 32'(CONvalid), 32'd0);
        @(negedge clk);
        model_result(r);
        check({tag, ".valid"}, 32'(CONvalid), 32'd1);
        check({tag, ".out"}, 32'(CONout), 32'(exp_out));
        check({tag, ".count"}, 32'(TakenCount), 32'(exp_cnt));
        @(negedge clk);
        check({tag, ".valid_drop"}, 32'(CONvalid), 32'd0);
        check({tag, ".out_hold"}, 32'(CONout), 32'(exp_out));
    endtask

    initial begin
        int pulses;
        bit rm;
        logic [2:0]  rc;
        logic [31:0] ra, rb;

        clr = 1'b0; CONin = 1'b0; CONclr = 1'b0;
        BusMuxOut = '0; IrBits = '0; CmpMode = 1'b0;
        #12;
        check("reset.out",   32'(CONout),     32'd0);
        check("reset.valid", 32'(CONvalid),   32'd0);
        check("reset.busy",  32'(Busy),       32'd0);
        check("reset.count", 32'(TakenCount), 32'd0);
        clr = 1'b1;
        @(negedge clk);

        // zero mode
        run_eval(1'b0, 3'b000, 32'h0000_0000, 32'h0, "zero_eq");
        run_eval(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, "zero_ge_neg");

        // signed boundary, two-operand mode
        run_eval(1'b1, 3'b011, 32'h8000_0000, 32'h7FFF_FFFF, "bound_lt");
        run_eval(1'b1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, "bound_gt");

        // strobe during EVAL is ignored
        CONin = 1'b1; BusMuxOut = 32'h0; IrBits = 3'b000; CmpMode = 1'b0;
        @(negedge clk);
        BusMuxOut = 32'h0000_0007;
        @(negedge clk);
        CONin = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (CONvalid) pulses++;
        end
        model_result(1'b1);
        check("ignore.pulses", 32'(pulses), 32'd1);
        check("ignore.out",    32'(CONout), 32'(exp_out));
        check("ignore.count",  32'(TakenCount), 32'(exp_cnt));

        // WAIT_B stall then abort
        CONin = 1'b1; BusMuxOut = 32'h1234_5678; IrBits = 3'b110; CmpMode = 1'b1;
        @(negedge clk);
        CONin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall.busy", 32'(Busy), 32'd1);
        end
        CONclr = 1'b1; CONin = 1'b1;
        @(negedge clk);
        CONclr = 1'b0; CONin = 1'b0;
        exp_out = 1'b0;
        check("abort.busy", 32'(Busy), 32'd0);
        check("abort.out",  32'(CONout), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (CONvalid) pulses++;
        end
        check("abort.pulses", 32'(pulses), 32'd0);
        check("abort.count",  32'(TakenCount), 32'(exp_cnt));

        // CONclr during EVAL suppresses the evaluation
        CONin = 1'b1; BusMuxOut = 32'h5; IrBits = 3'b110; CmpMode = 1'b0;
        @(negedge clk);
        CONin = 1'b0; CONclr = 1'b1;
        @(negedge clk);
        CONclr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (CONvalid) pulses++;
        end
        check("evalclr.pulses", 32'(pulses), 32'd0);
        check("evalclr.count",  32'(TakenCount), 32'(exp_cnt));
        check("evalclr.out",    32'(CONout), 32'd0);

        // randomized evaluations
        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom);
            rc = 3'($urandom);
            ra = pick_operand();
            rb = ($urandom_range(0, 3) == 0) ? ra : pick_operand();
            run_eval(rm, rc, ra, rb, "rand");
        end

        // async reset in the middle of EVAL
        run_eval(1'b0, 3'b110, 32'h9, 32'h0, "pre_reset");
        CONin = 1'b1; BusMuxOut = 32'h0; IrBits = 3'b110; CmpMode = 1'b0;
        @(negedge clk);
        CONin = 1'b0;
        #2 clr = 1'b0;
        #1;
        exp_cnt = 0; exp_out = 1'b0;
        check("arst.out",   32'(CONout),     32'd0);
        check("arst.valid", 32'(CONvalid),   32'd0);
        check("arst.busy",  32'(Busy),       32'd0);
        check("arst.count", 32'(TakenCount), 32'd0);
        @(negedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
        check("arst.no_valid", 32'(CONvalid), 32'd0);
        run_eval(1'b1, 3'b101, 32'hFFFF_FFFE, 32'h0000_0003, "post_reset");

        // saturation of the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            run_eval(1'($urandom), 3'b110, $urandom, $urandom, "sat");
        end
        check("sat.final", 32'(TakenCount), 32'(CNT_MAX));
        run_eval(1'b0, 3'b111, 32'h0, 32'h0, "never_z");
        run_eval(1'b1, 3'b111, 32'h3, 32'h3, "never_ab");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
